ex_alu_stage: RTL and testbench

- EX-stage datapath block of the 5-stage MIPS pipeline.
- Consumes the decoded ALUOp/ALUSrc controls plus the instruction funct field.
- Selects operand B, executes the ALU operation and registers the result into the EX/MEM pipeline register.
- Handles downstream stall and flush; can optionally host an iterative multiplier that back-pressures upstream.

---
 rtl/ex_alu_stage_if.sv | 27 ++
 rtl/ex_alu_stage.sv | 116 +++++++++++
 tb/tb_ex_alu_stage.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ex_alu_stage_if.sv
// ex_alu_stage_if: ID/EX operand bundle into the EX stage and the EX/MEM outputs it produces.
interface ex_alu_stage_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic [1:0]       ALUOp;
  logic             ALUSrc;
  logic [5:0]       Funct;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;
  logic [WIDTH-1:0] Imm;
  logic [4:0]       RdIn;
  logic             stall_in;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic [WIDTH-1:0] WriteData;
  logic [4:0]       RdOut;
  logic             busy;
  modport master (
    output in_valid, ALUOp, ALUSrc, Funct, ReadData1, ReadData2, Imm, RdIn, stall_in, flush,
    input  out_valid, ALUResult, Zero, WriteData, RdOut, busy
  );
  modport slave (
    input  in_valid, ALUOp, ALUSrc, Funct, ReadData1, ReadData2, Imm, RdIn, stall_in, flush,
    output out_valid, ALUResult, Zero, WriteData, RdOut, busy
  );
endinterface

// File: rtl/ex_alu_stage.sv
// ex_alu_stage: MIPS EX stage (operand B mux, ALU, EX/MEM register with stall/flush).
// Define EX_ALU_MULT_EN to add an iterative shift-add multiplier (Funct 011000) that asserts busy.
module ex_alu_stage #(
  parameter int WIDTH     = 32,
  parameter int MUL_STEPS = 32
) (
  input logic         clk,
  input logic         rst,
  ex_alu_stage_if.slave bus
);
  if (MUL_STEPS != WIDTH) begin : g_chk
    $error("MUL_STEPS must equal WIDTH");
  end
  logic [WIDTH-1:0] w_b, w_res;
  logic             w_idle, w_accept;
  logic             r_valid, r_zero;
  logic [WIDTH-1:0] r_res, r_wd;
  logic [4:0]       r_rd;
  assign w_b = bus.ALUSrc ? bus.Imm : bus.ReadData2;
  always_comb begin
    w_res = bus.ReadData1 + w_b;
    if (bus.ALUOp == 2'b01) w_res = bus.ReadData1 - w_b;
    else if (bus.ALUOp == 2'b10)
      case (bus.Funct)
        6'b100000: w_res = bus.ReadData1 + w_b;
        6'b100010: w_res = bus.ReadData1 - w_b;
        6'b100100: w_res = bus.ReadData1 & w_b;
        6'b100101: w_res = bus.ReadData1 | w_b;
        6'b101010: w_res = {{(WIDTH-1){1'b0}}, $signed(bus.ReadData1) < $signed(w_b)};
        default:   w_res = '0;
      endcase
  end
`ifdef EX_ALU_MULT_EN
  localparam int CW = $clog2(MUL_STEPS);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc, r_mwd;
  logic [4:0]       r_mrd;
  logic             w_fin;
  assign w_idle   = r_state == IDLE;
  assign w_accept = w_idle && bus.in_valid && bus.ALUOp == 2'b10 && bus.Funct == 6'b011000 &&
                    !bus.stall_in && !bus.flush;
  assign w_fin    = r_state == DONE && !bus.stall_in;
  assign bus.busy = !w_idle;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? MUL : IDLE;
      MUL:     w_next = bus.flush ? IDLE : (r_cnt == CW'(MUL_STEPS - 1) ? DONE : MUL);
      DONE:    w_next = (bus.flush || !bus.stall_in) ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // One partial product per cycle: multiplier consumed LSB first, multiplicand shifted up.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_mwd    <= '0;
      r_mrd    <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_mcand  <= bus.ReadData1;
      r_mplier <= w_b;
      r_acc    <= '0;
      r_mwd    <= bus.ReadData2;
      r_mrd    <= bus.RdIn;
    end else if (r_state == MUL) begin
      r_cnt    <= r_cnt + 1'b1;
      r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
`else
  assign w_idle   = 1'b1;
  assign w_accept = 1'b0;
  assign bus.busy = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_valid <= 1'b0;
      r_res   <= '0;
      r_zero  <= 1'b0;
      r_wd    <= '0;
      r_rd    <= '0;
    end else if (bus.flush) r_valid <= 1'b0;
`ifdef EX_ALU_MULT_EN
    else if (w_fin) begin
      r_valid <= 1'b1;
      r_res   <= r_acc;
      r_zero  <= r_acc == '0;
      r_wd    <= r_mwd;
      r_rd    <= r_mrd;
    end
`endif
    else if (w_idle && !bus.stall_in) begin
      r_valid <= bus.in_valid && !w_accept;
      if (!w_accept) begin
        r_res  <= w_res;
        r_zero <= w_res == '0;
        r_wd   <= bus.ReadData2;
        r_rd   <= bus.RdIn;
      end
    end
  assign bus.out_valid = r_valid;
  assign bus.ALUResult = r_res;
  assign bus.Zero      = r_zero;
  assign bus.WriteData = r_wd;
  assign bus.RdOut     = r_rd;
endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: directed vector table plus hand-written reset, stall/flush and multiply sequences.
module tb_ex_alu_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  always #5 clk = ~clk;
  ex_alu_stage_if #(.WIDTH(32)) bus ();
  ex_alu_stage #(.WIDTH(32), .MUL_STEPS(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct {
    logic        iv;
    logic [1:0]  op;
    logic        src;
    logic [5:0]  fn;
    logic [31:0] a, b, imm;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        z;
  } vec_t;
  vec_t v[11];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t x);
    bus.in_valid  = x.iv;
    bus.ALUOp     = x.op;
    bus.ALUSrc    = x.src;
    bus.Funct     = x.fn;
    bus.ReadData1 = x.a;
    bus.ReadData2 = x.b;
    bus.Imm       = x.imm;
    bus.RdIn      = x.rd;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string name, input logic v_e, input logic [31:0] r_e, input logic z_e,
                         input logic [31:0] wd_e, input logic [4:0] rd_e);
    chk({name, ".valid"}, {31'd0, bus.out_valid}, {31'd0, v_e});
    chk({name, ".res"}, bus.ALUResult, r_e);
    chk({name, ".zero"}, {31'd0, bus.Zero}, {31'd0, z_e});
    chk({name, ".wd"}, bus.WriteData, wd_e);
    chk({name, ".rd"}, {27'd0, bus.RdOut}, {27'd0, rd_e});
  endtask
  initial begin
    vec_t s;
    v[0]  = '{1'b1, 2'b10, 1'b0, 6'b101010, 32'hFFFFFFFF, 32'h1,        32'h0,        5'd3,  32'h1,        1'b0};
    v[1]  = '{1'b1, 2'b10, 1'b0, 6'b100010, 32'h5,        32'h5,        32'h0,        5'd4,  32'h0,        1'b1};
    v[2]  = '{1'b1, 2'b00, 1'b1, 6'b000000, 32'h1000,     32'hAB,       32'hFFFFFFFC, 5'd8,  32'h00000FFC, 1'b0};
    v[3]  = '{1'b1, 2'b10, 1'b0, 6'b111111, 32'h1234,     32'h5678,     32'h0,        5'd9,  32'h0,        1'b1};
    v[4]  = '{1'b1, 2'b00, 1'b0, 6'b000000, 32'h7FFFFFFF, 32'h1,        32'h0,        5'd10, 32'h80000000, 1'b0};
    v[5]  = '{1'b1, 2'b10, 1'b0, 6'b100100, 32'h0000F0F0, 32'h0000FF00, 32'h0,        5'd11, 32'h0000F000, 1'b0};
    v[6]  = '{1'b1, 2'b10, 1'b0, 6'b100101, 32'h0000F0F0, 32'h0000FF00, 32'h0,        5'd12, 32'h0000FFF0, 1'b0};
    v[7]  = '{1'b1, 2'b01, 1'b0, 6'b000000, 32'h3,        32'h5,        32'h0,        5'd13, 32'hFFFFFFFE, 1'b0};
    v[8]  = '{1'b1, 2'b11, 1'b1, 6'b000000, 32'h2,        32'h77,       32'h3,        5'd14, 32'h5,        1'b0};
    v[9]  = '{1'b0, 2'b00, 1'b0, 6'b000000, 32'h1,        32'h1,        32'h0,        5'd15, 32'h2,        1'b0};
    v[10] = '{1'b1, 2'b10, 1'b0, 6'b101010, 32'h1,        32'hFFFFFFFF, 32'h0,        5'd16, 32'h0,        1'b1};
    s = v[0];
    drive(s);
    bus.stall_in = 1'b0;
    bus.flush    = 1'b0;
    #12;
    chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
    chk("reset.busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk) rst = 1'b0;
    foreach (v[i]) begin
      @(negedge clk) drive(v[i]);
      tick();
      chk_out($sformatf("vec%0d", i), v[i].iv, v[i].res, v[i].z, v[i].b, v[i].rd);
      chk($sformatf("vec%0d.busy", i), {31'd0, bus.busy}, 32'd0);
    end
    @(negedge clk) drive(v[8]);
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk) begin
        drive(v[c]);
        bus.stall_in = 1'b1;
      end
      tick();
      chk_out($sformatf("stall%0d", c), 1'b1, 32'h5, 1'b0, 32'h77, 5'd14);
    end
    @(negedge clk) bus.flush = 1'b1;
    tick();
    chk_out("flush_stall", 1'b0, 32'h5, 1'b0, 32'h77, 5'd14);
    @(negedge clk) begin
      bus.flush = 1'b0;
      bus.stall_in = 1'b0;
      drive(v[2]);
    end
    tick();
    chk_out("after_flush", 1'b1, 32'h00000FFC, 1'b0, 32'hAB, 5'd8);
    #3 rst = 1'b1;
    #1 chk_out("async_reset", 1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
    @(negedge clk) rst = 1'b0;
`ifndef EX_ALU_MULT_EN
    s = '{1'b1, 2'b10, 1'b0, 6'b011000, 32'h3, 32'h7, 32'h0, 5'd5, 32'h0, 1'b1};
    @(negedge clk) drive(s);
    tick();
    chk_out("mulfunct_other", 1'b1, 32'h0, 1'b1, 32'h7, 5'd5);
    chk("mulfunct_busy", {31'd0, bus.busy}, 32'd0);
`else
    s = '{1'b1, 2'b10, 1'b0, 6'b011000, 32'hFFFFFFFD, 32'h7, 32'h0, 5'd21, 32'hFFFFFFEB, 1'b0};
    for (int m = 0; m < 3; m++) begin
      @(negedge clk) drive(s);
      tick();
      chk($sformatf("mul%0d.busyE", m), {31'd0, bus.busy}, 32'd1);
      chk($sformatf("mul%0d.validE", m), {31'd0, bus.out_valid}, 32'd0);
      @(negedge clk) bus.in_valid = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        if (m == 1 && k == 10) bus.flush = 1'b1;
        if (m == 2 && k == 30) bus.stall_in = 1'b1;
        if (m == 2 && k == 41) bus.stall_in = 1'b0;
        tick();
        @(negedge clk) begin
          bus.flush = 1'b0;
          if (m == 2 && k == 40) bus.stall_in = 1'b0;
        end
        if (m == 0 && k == 32) chk("mul0.busy32", {31'd0, bus.busy}, 32'd1);
        if (m == 0 && k == 33) chk_out("mul0.done", 1'b1, s.res, 1'b0, 32'h7, 5'd21);
        if (m == 0 && k == 33) chk("mul0.busy33", {31'd0, bus.busy}, 32'd0);
        if (m == 1 && k == 10) chk("mul1.busy", {31'd0, bus.busy}, 32'd0);
        if (m == 1 && k == 34) chk("mul1.valid", {31'd0, bus.out_valid}, 32'd0);
        if (m == 2 && k == 40) chk("mul2.stalled", {31'd0, bus.out_valid | !bus.busy}, 32'd0);
        if (m == 2 && k == 41) chk_out("mul2.done", 1'b1, s.res, 1'b0, 32'h7, 5'd21);
        if ((m == 0 && k == 33) || (m == 2 && k == 41)) break;
      end
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
